// File: rtl/button_event.sv
// Button event generator: turns a debounced, clk-synchronous button level
// into press / release / long-press / auto-repeat pulses, a held level and
// an 8-bit count of accepted presses.
module button_event #(
    parameter int ACTIVE_LOW  = 1,
    parameter int LONG_TIME   = 50_000_000,
    parameter int REPEAT_TIME = 10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_press,
    output logic       repeat_pulse,
    output logic       held,
    output logic [7:0] press_count
);

    // One shared counter times both the long-press hold and the repeat period.
    localparam int MAX_TIME = (LONG_TIME > REPEAT_TIME) ? LONG_TIME : REPEAT_TIME;
    localparam int CNT_W    = (MAX_TIME > 1) ? $clog2(MAX_TIME) : 1;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TIME - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TIME - 1);

    typedef enum logic [1:0] {
        WAIT_REL,
        IDLE,
        PRESSED,
        REPEAT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             pressed;

    // Normalise the button polarity; the input is already debounced and synchronous.
    assign pressed = (btn_in == (ACTIVE_LOW == 0));

    // Event FSM with registered outputs; a release always takes priority over a threshold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= WAIT_REL;
            cnt           <= '0;
            press_count   <= 8'd0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values;
            // the pulse defaults below are overridden later in the same block.
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;

            case (state)
                // A button already down at reset must be released before it counts.
                WAIT_REL: begin
                    if (!pressed) begin
                        state <= IDLE;
                    end
                end

                IDLE: begin
                    if (pressed) begin
                        state       <= PRESSED;
                        cnt         <= '0;
                        press_pulse <= 1'b1;
                        held        <= 1'b1;
                        press_count <= press_count + 8'd1;
                    end
                end

                PRESSED: begin
                    if (!pressed) begin
                        state         <= IDLE;
                        cnt           <= '0;
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                    end else if (cnt == LONG_LAST) begin
                        state      <= REPEAT;
                        cnt        <= '0;
                        long_press <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                REPEAT: begin
                    if (!pressed) begin
                        state         <= IDLE;
                        cnt           <= '0;
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                    end else if (cnt == REPEAT_LAST) begin
                        cnt          <= '0;
                        repeat_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= WAIT_REL;
                    cnt   <= '0;
                    held  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_event.sv
// Self-checking bench for button_event: directed scenarios plus random
// press/release segments, compared every cycle against a hold-length model.
module tb_button_event;

    localparam int LT = 10;
    localparam int RT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_in = 1'b1;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_press;
    logic       repeat_pulse;
    logic       held;
    logic [7:0] press_count;

    button_event #(
        .ACTIVE_LOW (1),
        .LONG_TIME  (LT),
        .REPEAT_TIME(RT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_in       (btn_in),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_press   (long_press),
        .repeat_pulse (repeat_pulse),
        .held         (held),
        .press_count  (press_count)
    );

    always #10 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: whether the button has been seen released since reset,
    // whether a press is in progress, and how many edges it has been held.
    bit       m_armed;
    bit       m_holding;
    int       m_hold_len;
    int       m_count;
    bit       e_press, e_release, e_long, e_rep;

    // Observed pulse timestamps for the directed timing scenario.
    int cyc;
    int t_press, t_long, t_rep_first, t_rep_last, n_long, n_rep;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_armed    = 1'b0;
        m_holding  = 1'b0;
        m_hold_len = 0;
        m_count    = 0;
        e_press    = 1'b0;
        e_release  = 1'b0;
        e_long     = 1'b0;
        e_rep      = 1'b0;
    endtask

    task automatic model_edge(input bit p);
        e_press   = 1'b0;
        e_release = 1'b0;
        e_long    = 1'b0;
        e_rep     = 1'b0;
        if (!m_armed) begin
            if (!p) m_armed = 1'b1;
        end else if (!m_holding) begin
            if (p) begin
                m_holding  = 1'b1;
                m_hold_len = 0;
                e_press    = 1'b1;
                m_count    = (m_count + 1) % 256;
            end
        end else if (!p) begin
            m_holding = 1'b0;
            e_release = 1'b1;
        end else begin
            m_hold_len++;
            if (m_hold_len == LT)
                e_long = 1'b1;
            else if (m_hold_len > LT && ((m_hold_len - LT) % RT) == 0)
                e_rep = 1'b1;
        end
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ".press_pulse"},   32'(press_pulse),   32'(e_press));
        check({ctx, ".release_pulse"}, 32'(release_pulse), 32'(e_release));
        check({ctx, ".long_press"},    32'(long_press),    32'(e_long));
        check({ctx, ".repeat_pulse"},  32'(repeat_pulse),  32'(e_rep));
        check({ctx, ".held"},          32'(held),          32'(m_holding));
        check({ctx, ".press_count"},   32'(press_count),   32'(m_count));
    endtask

    // One clock: drive the level just after an edge, sample 1 ns after the next edge.
    task automatic step(input bit p, input string ctx);
        btn_in = !p;
        @(posedge clk);
        model_edge(p);
        #1;
        cyc++;
        if (press_pulse)  t_press = cyc;
        if (long_press)   begin n_long++; t_long = cyc; end
        if (repeat_pulse) begin
            if (n_rep == 0) t_rep_first = cyc;
            t_rep_last = cyc;
            n_rep++;
        end
        check_all(ctx);
    endtask

    task automatic steps(input bit p, input int n, input string ctx);
        for (int i = 0; i < n; i++) step(p, ctx);
    endtask

    // Asynchronous reset asserted mid-cycle, checked before any clock edge.
    task automatic do_reset(input string ctx);
        #4 rst = 1'b1;
        model_reset();
        #1;
        check_all({ctx, ".async"});
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all({ctx, ".held_in_rst"});
        rst = 1'b0;
    endtask

    initial begin
        cyc = 0;
        model_reset();

        // Power-up reset with the button released.
        btn_in = 1'b1;
        #1;
        do_reset("reset0");
        steps(1'b0, 2, "idle0");

        // Short press: five cycles low.
        steps(1'b1, 5, "short");
        steps(1'b0, 3, "short_rel");
        check("short.count", 32'(press_count), 32'd1);

        // Long hold of twenty cycles: long press then two repeats.
        n_long = 0;
        n_rep  = 0;
        steps(1'b1, 20, "long");
        steps(1'b0, 3, "long_rel");
        check("long.n_long",    32'(n_long), 32'd1);
        check("long.n_rep",     32'(n_rep), 32'd2);
        check("long.t_long",    32'(t_long - t_press), 32'd10);
        check("long.t_rep1",    32'(t_rep_first - t_press), 32'd14);
        check("long.t_rep2",    32'(t_rep_last - t_press), 32'd18);

        // Release exactly on the long-press threshold edge, then on a repeat edge.
        n_long = 0;
        steps(1'b1, LT, "edge_long");
        steps(1'b0, 2, "edge_long_rel");
        check("edge_long.n_long", 32'(n_long), 32'd0);
        n_rep = 0;
        steps(1'b1, LT + RT, "edge_rep");
        steps(1'b0, 2, "edge_rep_rel");
        check("edge_rep.n_rep", 32'(n_rep), 32'd0);

        // Button held across reset release: ignored until released and pressed again.
        btn_in = 1'b0;
        do_reset("rst_held");
        steps(1'b1, 6, "held_after_rst");
        check("held_after_rst.count", 32'(press_count), 32'd0);
        steps(1'b0, 2, "held_rel");
        steps(1'b1, 3, "held_repress");
        steps(1'b0, 2, "held_repress_rel");
        check("held_repress.count", 32'(press_count), 32'd1);

        // Counter wrap: 256 single-cycle presses from a fresh reset.
        btn_in = 1'b1;
        do_reset("rst_wrap");
        steps(1'b0, 1, "wrap_arm");
        for (int i = 0; i < 256; i++) begin
            step(1'b1, "wrap_p");
            step(1'b0, "wrap_r");
        end
        check("wrap.count256", 32'(press_count), 32'd0);
        step(1'b1, "wrap_p257");
        step(1'b0, "wrap_r257");
        check("wrap.count257", 32'(press_count), 32'd1);

        // Random press/release segments.
        for (int s = 0; s < 40; s++) begin
            steps(1'b1, int'($urandom_range(1, 25)), "rand_hold");
            steps(1'b0, int'($urandom_range(1, 4)), "rand_gap");
        end

        // Reset during auto-repeat: immediate clear, no release pulse afterwards.
        steps(1'b1, LT + RT + 2, "pre_abort");
        check("pre_abort.held", 32'(held), 32'd1);
        do_reset("abort");
        steps(1'b1, 3, "abort_still_held");
        steps(1'b0, 2, "abort_rel");
        steps(1'b1, 2, "abort_repress");
        steps(1'b0, 2, "abort_repress_rel");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
